// File: rtl/proc_out_port_bank.sv
// proc_out_port_bank
//   Bank of p_nchan output channels, each a p_depth-entry FIFO drained by an
//   external val/rdy consumer, plus a shadow of the last accepted write.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   wr_en      processor write request
//   wr_chan    target channel index
//   wr_data    write data
//   wr_stall   combinational: request not accepted this cycle (target full)
//   wr_err     registered pulse: previous write targeted a nonexistent channel
//   out_val    per-channel head valid
//   out_rdy    per-channel consumer ready
//   out_data   per-channel head data, channel i at [i*p_nbits +: p_nbits]
//   last       per-channel most recent accepted write, same packing
//   occ        per-channel occupancy, channel i at [i*OW +: OW]
module proc_out_port_bank #(
    parameter int p_nchan = 3,
    parameter int p_nbits = 32,
    parameter int p_depth = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [((p_nchan > 1) ? $clog2(p_nchan) : 1)-1:0] wr_chan,
    input  logic [p_nbits-1:0]                    wr_data,
    output logic                                  wr_stall,
    output logic                                  wr_err,
    output logic [p_nchan-1:0]                    out_val,
    input  logic [p_nchan-1:0]                    out_rdy,
    output logic [p_nchan*p_nbits-1:0]            out_data,
    output logic [p_nchan*p_nbits-1:0]            last,
    output logic [p_nchan*$clog2(p_depth+1)-1:0]  occ
);

    localparam int CW = (p_nchan > 1) ? $clog2(p_nchan) : 1;
    localparam int OW = $clog2(p_depth + 1);
    localparam int PW = $clog2(p_depth);

    logic [p_nbits-1:0] mem_q  [p_nchan][p_depth];
    logic [p_nbits-1:0] mem_d  [p_nchan][p_depth];
    logic [PW-1:0]      head_q [p_nchan];
    logic [PW-1:0]      head_d [p_nchan];
    logic [PW-1:0]      tail_q [p_nchan];
    logic [PW-1:0]      tail_d [p_nchan];
    logic [OW-1:0]      occ_q  [p_nchan];
    logic [OW-1:0]      occ_d  [p_nchan];
    logic [p_nbits-1:0] last_q [p_nchan];
    logic [p_nbits-1:0] last_d [p_nchan];
    logic               wr_err_q;
    logic               wr_err_d;

    logic [p_nchan-1:0] hit;
    logic [p_nchan-1:0] full;
    logic [p_nchan-1:0] enq;
    logic [p_nchan-1:0] deq;

    // Channel decode by comparison loop, so an out-of-range wr_chan simply
    // matches no channel instead of indexing past the arrays.
    always_comb begin
        hit      = '0;
        full     = '0;
        for (int unsigned i = 0; i < p_nchan; i++) begin
            hit[i]     = wr_en && (wr_chan == CW'(i));
            full[i]    = (occ_q[i] == OW'(p_depth));
            out_val[i] = (occ_q[i] != '0);
        end
        // A full channel still accepts a write when its head leaves this cycle.
        wr_stall = |(hit & full & ~out_rdy);
        wr_err_d = wr_en && (hit == '0);
        enq      = wr_stall ? '0 : hit;
        deq      = out_val & out_rdy;
    end

    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < p_nchan; i++) begin
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            occ_d[i]  = occ_q[i];
            last_d[i] = last_q[i];
            if (enq[i]) begin
                mem_d[i][tail_q[i]] = wr_data;
                last_d[i]           = wr_data;
                tail_d[i] = (tail_q[i] == PW'(p_depth - 1)) ? '0 : tail_q[i] + 1'b1;
            end
            if (deq[i]) begin
                head_d[i] = (head_q[i] == PW'(p_depth - 1)) ? '0 : head_q[i] + 1'b1;
            end
            if (enq[i] && !deq[i]) begin
                occ_d[i] = occ_q[i] + 1'b1;
            end else if (deq[i] && !enq[i]) begin
                occ_d[i] = occ_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
            for (int unsigned i = 0; i < p_nchan; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                occ_q[i]  <= '0;
                last_q[i] <= '0;
            end
        end else begin
            wr_err_q <= wr_err_d;
            for (int unsigned i = 0; i < p_nchan; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                occ_q[i]  <= occ_d[i];
                last_q[i] <= last_d[i];
            end
        end
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        wr_err = wr_err_q;
        for (int unsigned i = 0; i < p_nchan; i++) begin
            out_data[i*p_nbits +: p_nbits] = out_val[i] ? mem_q[i][head_q[i]] : '0;
            last[i*p_nbits +: p_nbits]     = last_q[i];
            occ[i*OW +: OW]                = occ_q[i];
        end
    end

endmodule
